// File: rtl/uart_rx_parity_if.sv
// uart_rx_parity_if
// Bundles the serial line, parity selection and received-byte signals of
// the UART receiver into one port.
//   rx            serial line into the receiver; idles high
//   parity_type   2'b01 odd, 2'b10 even, 2'b00/2'b11 no parity bit
//   data_out      last received byte
//   data_valid    one-clock strobe per completed frame
//   parity_error  parity mismatch in the last frame
//   framing_error stop bit sampled low in the last frame
//   busy          receiver is inside a frame (not idle)
// Modports:
//   master  the receiver; drives the byte and status outputs
//   slave   the line driver / byte consumer on the other side
interface uart_rx_parity_if;
  logic       rx;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  modport master (
    input  rx,
    input  parity_type,
    output data_out,
    output data_valid,
    output parity_error,
    output framing_error,
    output busy
  );

  modport slave (
    output rx,
    output parity_type,
    input  data_out,
    input  data_valid,
    input  parity_error,
    input  framing_error,
    input  busy
  );
endinterface

// File: rtl/uart_rx_parity.sv
// uart_rx_parity
// UART receiver with 16x oversampling, 8 data bits LSB first, optional
// odd/even parity bit and one stop bit. Each completed frame loads the
// byte and error flags and pulses data_valid for one clock.
// Ports:
//   clk_i     system clock, rising edge
//   reset_ni  asynchronous active-low reset
//   bus       uart_rx_parity_if.master (rx, parity_type in; data_out,
//             data_valid, parity_error, framing_error, busy out)
// Parameter:
//   DIV       clocks per oversample tick (>= 2); bit period is 16*DIV
// Configuration macro:
//   UART_RX_MAJORITY_EN  when defined, each bit is the 2-of-3 majority of
//                        samples at ticks 7, 8 and 9, decided at tick 9;
//                        otherwise a single sample at tick 8 is used.
module uart_rx_parity #(
  parameter int DIV = 27
) (
  input logic              clk_i,
  input logic              reset_ni,
  uart_rx_parity_if.master bus
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  // tickCnt_q holds the number of ticks already seen in the current bit,
  // so the tick arriving while it reads 7 is tick index 8 of the bit.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DEC_TICK = 4'd8;
`else
  localparam logic [3:0] DEC_TICK = 4'd7;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

  state_e         state_q, state_d;
  logic           rxMeta_q, rxSync_q, rxPrev_q;
  logic [DW-1:0]  divCnt_q;
  logic [3:0]     tickCnt_q;
  logic [2:0]     bitCnt_q;
  logic [7:0]     shift_q;
  logic [1:0]     ptype_q;
  logic           perr_q;
  logic [7:0]     dataOut_q;
  logic           dataValid_q, parityErr_q, framingErr_q;

  logic tick, decide, bitVal, startEdge, hasParity, expParity;
  logic runCnt, shiftEn, parityEn, frameDone, busy;

  assign tick      = (divCnt_q == DIV_LAST);
  assign decide    = tick && (tickCnt_q == DEC_TICK);
  assign startEdge = rxPrev_q && !rxSync_q;
  assign hasParity = (ptype_q == 2'b01) || (ptype_q == 2'b10);
  // Odd mode sends 1 when the data holds an even number of ones.
  assign expParity = (ptype_q == 2'b01) ? ~^shift_q : ^shift_q;

`ifdef UART_RX_MAJORITY_EN
  logic smpA_q, smpB_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      smpA_q <= 1'b1;
      smpB_q <= 1'b1;
    end else if (tick) begin
      if (tickCnt_q == 4'd6) smpA_q <= rxSync_q;
      if (tickCnt_q == 4'd7) smpB_q <= rxSync_q;
    end
  end

  assign bitVal = (smpA_q & smpB_q) | (smpA_q & rxSync_q) | (smpB_q & rxSync_q);
`else
  assign bitVal = rxSync_q;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (startEdge) state_d = START;
      START:     if (decide) state_d = bitVal ? IDLE : DATA;
      DATA:      if (decide && bitCnt_q == 3'd7) state_d = hasParity ? PARITY : STOP;
      PARITY:    if (decide) state_d = STOP;
      STOP:      if (decide) state_d = bitVal ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxSync_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    runCnt    = (state_q != IDLE) && (state_q != WAIT_HIGH);
    shiftEn   = (state_q == DATA) && decide;
    parityEn  = (state_q == PARITY) && decide;
    frameDone = (state_q == STOP) && decide;
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rxMeta_q     <= 1'b1;
      rxSync_q     <= 1'b1;
      rxPrev_q     <= 1'b1;
      divCnt_q     <= '0;
      tickCnt_q    <= 4'd0;
      bitCnt_q     <= 3'd0;
      shift_q      <= 8'h00;
      ptype_q      <= 2'b00;
      perr_q       <= 1'b0;
      dataOut_q    <= 8'h00;
      dataValid_q  <= 1'b0;
      parityErr_q  <= 1'b0;
      framingErr_q <= 1'b0;
    end else begin
      rxMeta_q <= bus.rx;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;

      if (!runCnt) begin
        divCnt_q  <= '0;
        tickCnt_q <= 4'd0;
      end else if (tick) begin
        divCnt_q  <= '0;
        tickCnt_q <= tickCnt_q + 4'd1;
      end else begin
        divCnt_q <= divCnt_q + DW'(1);
      end

      // The parity mode is frozen at the start edge so later changes on
      // parity_type cannot disturb the frame in flight.
      if (state_q == IDLE && startEdge) begin
        ptype_q  <= bus.parity_type;
        perr_q   <= 1'b0;
        bitCnt_q <= 3'd0;
      end

      if (shiftEn) begin
        shift_q  <= {bitVal, shift_q[7:1]};
        bitCnt_q <= bitCnt_q + 3'd1;
      end

      if (parityEn) perr_q <= (bitVal != expParity);

      dataValid_q <= frameDone;
      if (frameDone) begin
        dataOut_q    <= shift_q;
        parityErr_q  <= perr_q;
        framingErr_q <= !bitVal;
      end
    end
  end

  assign bus.data_out      = dataOut_q;
  assign bus.data_valid    = dataValid_q;
  assign bus.parity_error  = parityErr_q;
  assign bus.framing_error = framingErr_q;
  assign bus.busy          = busy;

endmodule
